imm_extend_pipe: RTL and testbench

Parametrised immediate generator with a registered Decode->Execute stage. It builds the XLEN-wide immediate from the instruction word for all RV32I/RV64I formats, plus CSR zimm and shift-amount modes. It registers the result into the E stage with stall/flush control, a valid bit and an illegal-mode flag. It replaces the combinational Decode-stage extender, feeding the E-stage ALU operand mux and branch target adder directly.

---
 rtl/imm_extend_pipe.sv | 113 +++++++++++
 tb/tb_imm_extend_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Builds the XLEN-wide immediate for the Decode-stage instruction (RV32I/RV64I
//   formats plus CSR zimm and shift amount) and registers it into Execute.
//   The E-stage register also carries a valid bit and an illegal-format flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears the E-stage register
//   InstrD       instruction word in Decode
//   ImmSrcD      immediate format select (111 is undefined)
//   ValidD       Decode holds a real instruction
//   StallE       hold E-stage register contents
//   FlushE       load a bubble into E (takes priority over StallE)
//   ExtImmE      registered extended immediate
//   ValidE       registered valid
//   IllegalImmE  registered flag: undefined ImmSrcD with ValidD=1
module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic [2:0]      ImmSrcD,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [XLEN-1:0] ExtImmE,
    output logic            ValidE,
    output logic            IllegalImmE
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_Z     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_UNDEF = 3'b111
    } imm_src_e;

    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_d;
    logic               illegal_d;

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^InstrD[6:0];

    // Formats I..J are first formed as a signed 32-bit value; the final signed
    // cast widens it, so XLEN=64 sign-extends from bit 31 with the low word
    // identical to XLEN=32.
    always_comb begin
        imm32     = '0;
        imm_d     = '0;
        illegal_d = 1'b0;
        case (imm_src_e'(ImmSrcD))
            IMM_I: begin
                imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
                imm_d = XLEN'(imm32);
            end
            IMM_S: begin
                imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                imm_d = XLEN'(imm32);
            end
            IMM_B: begin
                imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                         InstrD[30:25], InstrD[11:8], 1'b0};
                imm_d = XLEN'(imm32);
            end
            IMM_U: begin
                imm32 = {InstrD[31:12], 12'b0};
                imm_d = XLEN'(imm32);
            end
            IMM_J: begin
                imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                         InstrD[20], InstrD[30:21], 1'b0};
                imm_d = XLEN'(imm32);
            end
            IMM_Z: begin
                imm_d = XLEN'(InstrD[19:15]);
            end
            IMM_SHAMT: begin
                if (XLEN == 64) imm_d = XLEN'(InstrD[25:20]);
                else            imm_d = XLEN'(InstrD[24:20]);
            end
            IMM_UNDEF: begin
                imm_d     = '0;
                illegal_d = ValidD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ExtImmE     <= '0;
            ValidE      <= 1'b0;
            IllegalImmE <= 1'b0;
        end else if (!StallE) begin
            ExtImmE     <= imm_d;
            ValidE      <= ValidD;
            IllegalImmE <= illegal_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: drives one XLEN=32 and one XLEN=64 instance
// from shared inputs and checks both against an arithmetic reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] InstrD;
    logic [2:0]  ImmSrcD;
    logic        ValidD, StallE, FlushE;

    logic [31:0] imm32;
    logic        v32, il32;
    logic [63:0] imm64;
    logic        v64, il64;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] e_imm64;
    logic [31:0] e_imm32;
    logic        e_v, e_il;

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ImmSrcD(ImmSrcD),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
        .ExtImmE(imm32), .ValidE(v32), .IllegalImmE(il32)
    );

    imm_extend_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ImmSrcD(ImmSrcD),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
        .ExtImmE(imm64), .ValidE(v64), .IllegalImmE(il64)
    );

    // Reference immediate, computed with arithmetic shifts on a sign-extended word.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                            input logic [2:0] src,
                                            input bit x64);
        longint s;
        logic [63:0] r;
        s = longint'($signed(ins));
        case (src)
            3'd0: r = 64'(s >>> 20);
            3'd1: r = 64'((s >>> 25) <<< 5) | 64'(ins[11:7]);
            3'd2: r = 64'((s >>> 31) <<< 12) | (64'(ins[7]) << 11)
                    | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            3'd3: r = 64'(s) & ~64'hFFF;
            3'd4: r = 64'((s >>> 31) <<< 20) | (64'(ins[19:12]) << 12)
                    | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            3'd5: r = 64'(ins[19:15]);
            3'd6: r = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: model the register update from the inputs held now,
    // then compare both instances #1 after the edge.
    task automatic tick();
        logic [63:0] n64, n32;
        logic        nv, nil;
        bit          upd;
        upd = 1'b1;
        if (reset || FlushE) begin
            n64 = '0; n32 = '0; nv = 1'b0; nil = 1'b0;
        end else if (StallE) begin
            upd = 1'b0;
            n64 = e_imm64; n32 = 64'(e_imm32); nv = e_v; nil = e_il;
        end else begin
            n64 = ref_imm(InstrD, ImmSrcD, 1'b1);
            n32 = ref_imm(InstrD, ImmSrcD, 1'b0);
            nv  = ValidD;
            nil = ValidD && (ImmSrcD == 3'b111);
        end
        @(posedge clk);
        #1;
        if (upd || 1'b1) begin
            e_imm64 = n64;
            e_imm32 = n32[31:0];
            e_v     = nv;
            e_il    = nil;
        end
        chk("imm32",   64'(imm32), 64'(e_imm32));
        chk("imm64",   imm64,      e_imm64);
        chk("valid32", 64'(v32),   64'(e_v));
        chk("valid64", 64'(v64),   64'(e_v));
        chk("ill32",   64'(il32),  64'(e_il));
        chk("ill64",   64'(il64),  64'(e_il));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic vd,
                         input logic st, input logic fl, input logic rs);
        InstrD = ins; ImmSrcD = src; ValidD = vd; StallE = st; FlushE = fl; reset = rs;
    endtask

    initial begin
        e_imm64 = '0; e_imm32 = '0; e_v = 1'b0; e_il = 1'b0;

        // Reset held two cycles with a live I-type instruction in Decode
        drive(32'hFFF00093, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rst_imm32_a", 64'(imm32), 64'h0);
        chk("rst_valid_a", 64'(v32), 64'h0);
        tick();
        chk("rst_imm64_b", imm64, 64'h0);
        chk("rst_ill_b", 64'(il64), 64'h0);

        // First load one cycle after deassert
        reset = 1'b0;
        tick();
        chk("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("I_valid", 64'(v32), 64'h1);

        drive(32'hFE000EE3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("B_imm32", 64'(imm32), 64'hFFFF_FFFC);

        // J +8, then stall three cycles with a new I-type input
        drive(32'h0080006F, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("J_imm32", 64'(imm32), 64'h8);
        drive(32'hFFF00093, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 64'(imm32), 64'h8);
        end
        drive(32'hFFF00093, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("flush_imm", 64'(imm32), 64'h0);
        chk("flush_valid", 64'(v64), 64'h0);

        // CSR zimm and shift amount
        drive(32'h000AD073, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("Z_imm32", 64'(imm32), 64'h15);
        drive(32'h01F0D093, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("SH_imm32", 64'(imm32), 64'h1F);
        drive(32'h03F0D093, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("SH64_imm64", imm64, 64'h3F);
        chk("SH64_imm32", 64'(imm32), 64'h1F);

        // U-type with bit 31 set
        drive(32'h800000B7, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("U_imm32", 64'(imm32), 64'h8000_0000);

        // Undefined format, with and without a valid instruction
        drive(32'hDEADBEEF, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ILL_imm", imm64, 64'h0);
        chk("ILL_flag", 64'(il32), 64'h1);
        drive(32'hDEADBEEF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ILL_bubble", 64'(il64), 64'h0);
        chk("ILL_bubble_v", 64'(v32), 64'h0);

        // Reset during a stall clears; the stall then holds the cleared value
        drive(32'hFFF00093, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h0080006F, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_stall", 64'(imm32), 64'h0);
        reset = 1'b0;
        tick();
        chk("stall_after_rst", 64'(imm32), 64'h0);
        chk("stall_after_rst_v", 64'(v32), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
